// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared defaults, FSM state type and sizing helper for the memory-port arbiter
package mem_bus_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first pending port after the last grant
module rr_arbiter
    import mem_bus_pkg::*;
#(
    parameter  int N  = 2,
    localparam int GW = clog2_min1(N)
) (
    input  logic [N-1:0]  i_pending,
    input  logic [GW-1:0] i_last,
    output logic [GW-1:0] o_idx,
    output logic          o_any
);

    logic [GW-1:0] w_idx;

    // scan farthest-to-nearest so the nearest pending port after i_last is written last and wins
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        w_idx = '0;
        for (int k = N; k >= 1; k--) begin
            w_idx = GW'((int'(i_last) + k) % N);
            if (i_pending[w_idx]) begin
                o_idx = w_idx;
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: buffers one request per port, grants round-robin, runs one memory transaction at a time with timeout
module mem_port_arbiter
    import mem_bus_pkg::*;
#(
    parameter  int          N_PORTS        = 2,
    parameter  int          ADDR_W         = DEF_ADDR_W,
    parameter  int          DATA_W         = DEF_DATA_W,
    parameter  int          TIMEOUT_CYCLES = 255,
    parameter  logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF,
    localparam int          MASK_W         = DATA_W / 8,
    localparam int          GW             = clog2_min1(N_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PORTS-1:0]          req_begin,
    input  logic [N_PORTS*ADDR_W-1:0]   req_address,
    input  logic [N_PORTS*DATA_W-1:0]   req_data_out,
    input  logic [N_PORTS-1:0]          req_write_enable,
    input  logic [N_PORTS*MASK_W-1:0]   req_write_mask,
    output logic [N_PORTS-1:0]          req_end,
    output logic [DATA_W-1:0]           req_data_in,
    output logic                        mem_begin,
    output logic [ADDR_W-1:0]           mem_address,
    output logic [DATA_W-1:0]           mem_data_out,
    output logic                        mem_write_enable,
    output logic [MASK_W-1:0]           mem_write_mask,
    input  logic                        mem_end,
    input  logic [DATA_W-1:0]           mem_data_in,
    output logic                        busy,
    output logic [GW-1:0]               grant,
    output logic [N_PORTS-1:0]          overrun,
    output logic                        timeout_err
);

    localparam int CNT_W = clog2_min1(TIMEOUT_CYCLES + 1);

    arb_state_t          r_state, w_next;
    logic [N_PORTS-1:0]  r_pending, r_overrun, r_req_end, r_buf_we;
    logic [N_PORTS-1:0]  w_clr, w_free, w_cap;
    logic [ADDR_W-1:0]   r_buf_addr [N_PORTS];
    logic [DATA_W-1:0]   r_buf_data [N_PORTS];
    logic [MASK_W-1:0]   r_buf_mask [N_PORTS];
    logic [GW-1:0]       r_grant, w_pick;
    logic                w_any, w_mem_done, w_timeout, w_done;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_req_data_in, r_mem_data_out;
    logic [ADDR_W-1:0]   r_mem_address;
    logic [MASK_W-1:0]   r_mem_mask;
    logic                r_mem_begin, r_mem_we, r_busy, r_timeout_err;

    rr_arbiter #(.N(N_PORTS)) u_rr (
        .i_pending (r_pending),
        .i_last    (r_grant),
        .o_idx     (w_pick),
        .o_any     (w_any)
    );

    assign w_clr  = w_done ? (N_PORTS'(1) << r_grant) : '0;
    assign w_free = ~r_pending | w_clr;
    assign w_cap  = req_begin & w_free;

    // latch new requests; a port completing on this edge can be refilled on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_overrun <= '0;
            r_buf_we  <= '0;
            for (int i = 0; i < N_PORTS; i++) begin
                r_buf_addr[i] <= '0;
                r_buf_data[i] <= '0;
                r_buf_mask[i] <= '0;
            end
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_cap;
            r_overrun <= r_overrun | (req_begin & ~w_free);
            for (int i = 0; i < N_PORTS; i++) begin
                if (w_cap[i]) begin
                    r_buf_addr[i] <= req_address[i*ADDR_W +: ADDR_W];
                    r_buf_data[i] <= req_data_out[i*DATA_W +: DATA_W];
                    r_buf_mask[i] <= req_write_mask[i*MASK_W +: MASK_W];
                    r_buf_we[i]   <= req_write_enable[i];
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_next;
    end

    // next state: mem_end counts in ISSUE (zero-wait memory) and WAIT, never in IDLE
    always_comb begin
        w_mem_done = (r_state != IDLE) && mem_end;
        w_timeout  = (TIMEOUT_CYCLES != 0) && (r_state == WAIT) && !mem_end
                     && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
        w_done     = w_mem_done || w_timeout;
        w_next     = (r_state == IDLE) ? (w_any ? ISSUE : IDLE) : (w_done ? IDLE : WAIT);
    end

    // registered outputs: downstream fields load only on a new grant and hold until the next one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant       <= GW'(N_PORTS - 1);
            r_mem_begin   <= 1'b0;
            r_mem_address <= '0;
            r_mem_data_out<= '0;
            r_mem_we      <= 1'b0;
            r_mem_mask    <= '0;
            r_req_end     <= '0;
            r_req_data_in <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_mem_begin <= (w_next == ISSUE);
            r_busy      <= (w_next != IDLE);
            r_req_end   <= w_clr;
            r_cnt       <= (r_state == WAIT) ? r_cnt + 1'b1 : '0;
            if (w_timeout) r_timeout_err <= 1'b1;
            if (w_done) r_req_data_in <= w_timeout ? DATA_W'(TIMEOUT_DATA) : mem_data_in;
            if (r_state == IDLE && w_any) begin
                r_grant        <= w_pick;
                r_mem_address  <= r_buf_addr[w_pick];
                r_mem_data_out <= r_buf_data[w_pick];
                r_mem_mask     <= r_buf_mask[w_pick];
                r_mem_we       <= r_buf_we[w_pick];
            end
        end
    end

    assign req_end          = r_req_end;
    assign req_data_in      = r_req_data_in;
    assign mem_begin        = r_mem_begin;
    assign mem_address      = r_mem_address;
    assign mem_data_out     = r_mem_data_out;
    assign mem_write_enable = r_mem_we;
    assign mem_write_mask   = r_mem_mask;
    assign busy             = r_busy;
    assign grant            = r_grant;
    assign overrun          = r_overrun;
    assign timeout_err      = r_timeout_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench with a behavioural memory responder
module tb_mem_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int TO = 8;

    typedef struct {
        logic [1:0]  port;
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
        logic [3:0]  mask;
    } iss_t;

    typedef struct {
        logic [1:0]  port;
        logic [31:0] data;
        logic        chk_data;
        logic        to;
    } end_t;

    typedef struct {
        int          lat;
        logic [31:0] data;
    } resp_t;

    logic              clk, rst;
    logic [NP-1:0]     req_begin, req_write_enable, req_end, overrun;
    logic [NP*AW-1:0]  req_address;
    logic [NP*DW-1:0]  req_data_out;
    logic [NP*MW-1:0]  req_write_mask;
    logic [DW-1:0]     req_data_in, mem_data_out, mem_data_in;
    logic [AW-1:0]     mem_address;
    logic [MW-1:0]     mem_write_mask;
    logic              mem_begin, mem_write_enable, mem_end, busy, timeout_err;
    logic [1:0]        grant;

    iss_t  iss_q[$];
    end_t  end_q[$];
    resp_t resp_q[$];
    iss_t  ie;
    end_t  ee;
    resp_t re;
    logic  prev_mem_end;
    int    checks, errors;

    mem_port_arbiter #(
        .N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .rst(rst),
        .req_begin(req_begin), .req_address(req_address), .req_data_out(req_data_out),
        .req_write_enable(req_write_enable), .req_write_mask(req_write_mask),
        .req_end(req_end), .req_data_in(req_data_in),
        .mem_begin(mem_begin), .mem_address(mem_address), .mem_data_out(mem_data_out),
        .mem_write_enable(mem_write_enable), .mem_write_mask(mem_write_mask),
        .mem_end(mem_end), .mem_data_in(mem_data_in),
        .busy(busy), .grant(grant), .overrun(overrun), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        req_begin = '0;
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] d,
                           input logic we, input logic [3:0] m);
        req_begin[p]              = 1'b1;
        req_address[p*AW +: AW]   = a;
        req_data_out[p*DW +: DW]  = d;
        req_write_enable[p]       = we;
        req_write_mask[p*MW +: MW] = m;
    endtask

    // lat < 0: memory never answers; lat > TO: answer arrives after the timeout
    task automatic req(input int p, input logic [31:0] a, input logic [31:0] d, input logic we,
                       input logic [3:0] m, input int lat, input logic [31:0] rd, input logic exp_end);
        logic to;
        to = (lat < 0) || (lat > TO);
        set_req(p, a, d, we, m);
        iss_q.push_back('{port: 2'(p), addr: a, data: d, we: we, mask: m});
        resp_q.push_back('{lat: lat, data: rd});
        if (exp_end)
            end_q.push_back('{port: 2'(p), data: to ? 32'hDEAD_BEEF : rd, chk_data: !we || to, to: to});
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (iss_q.size() == 0 && end_q.size() == 0 && !busy) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: still busy after %0d cycles, issues left %0d ends left %0d",
                 budget, iss_q.size(), end_q.size());
    endtask

    task automatic check_reset();
        chk("rst_req_end", req_end, 0);
        chk("rst_mem_begin", mem_begin, 0);
        chk("rst_mem_we", mem_write_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_req_data_in", req_data_in, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_data_out", mem_data_out, 0);
        chk("rst_mem_mask", mem_write_mask, 0);
        chk("rst_grant", grant, 3);
    endtask

    // memory model: answers each mem_begin after the scripted number of cycles (0 = same cycle)
    initial begin
        mem_end = 1'b0;
        mem_data_in = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_end = 1'b0;
            if (mem_begin && resp_q.size() != 0) begin
                re = resp_q.pop_front();
                if (re.lat >= 0) begin
                    repeat (re.lat) begin
                        @(posedge clk);
                        #1;
                    end
                    mem_end = 1'b1;
                    mem_data_in = re.data;
                end
            end
        end
    end

    // monitor: compares every downstream issue and every requester completion against the queues
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_begin) begin
                if (iss_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL issue: unexpected mem_begin at address %0h", mem_address);
                end else begin
                    ie = iss_q.pop_front();
                    chk("issue_grant", grant, ie.port);
                    chk("issue_addr", mem_address, ie.addr);
                    chk("issue_we", mem_write_enable, ie.we);
                    chk("issue_mask", mem_write_mask, ie.mask);
                    if (ie.we) chk("issue_wdata", mem_data_out, ie.data);
                end
            end
            if (req_end != 0) begin
                if (end_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL end: unexpected req_end %b", req_end);
                end else begin
                    ee = end_q.pop_front();
                    chk("end_port", req_end, 4'b0001 << ee.port);
                    chk("end_grant", grant, ee.port);
                    if (ee.chk_data) chk("end_data", req_data_in, ee.data);
                    if (!ee.to) chk("end_latency", prev_mem_end, 1);
                end
            end
        end
        prev_mem_end = mem_end;
    end

    initial begin
        checks = 0;
        errors = 0;
        prev_mem_end = 1'b0;
        rst = 1'b1;
        req_begin = '0;
        req_write_enable = '0;
        req_address = '0;
        req_data_out = '0;
        req_write_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset();

        // simultaneous begins from reset: port0 then port1
        req(0, 32'h0000_0010, 0, 0, 0, 2, 32'h0A0A_0A0A, 1);
        req(1, 32'h0000_0014, 0, 0, 0, 2, 32'h1B1B_1B1B, 1);
        tick();
        wait_idle(40);
        chk("grant_after_pair", grant, 1);

        // single read with begin-to-issue latency checks
        req(0, 32'h0000_0100, 0, 0, 0, 3, 32'h1234_5678, 1);
        tick();
        chk("lat_no_begin_yet", mem_begin, 0);
        chk("lat_not_busy_yet", busy, 0);
        tick();
        chk("lat_begin", mem_begin, 1);
        chk("lat_busy", busy, 1);
        tick();
        chk("begin_one_cycle", mem_begin, 0);
        wait_idle(40);
        chk("busy_after_read", busy, 0);

        // all four ports, zero-wait memory; port1 refilled on its own completion edge
        req(1, 32'h0000_1010, 0, 0, 0, 0, 32'hA000_0001, 1);
        req(2, 32'h0000_1020, 32'h2222_0000, 1, 4'hF, 0, 0, 1);
        req(3, 32'h0000_1030, 0, 0, 0, 0, 32'hA000_0003, 1);
        req(0, 32'h0000_1000, 0, 0, 0, 0, 32'hA000_0000, 1);
        tick();
        tick();
        req(1, 32'h0000_2000, 0, 0, 0, 0, 32'hA000_0011, 1);
        tick();
        wait_idle(60);
        chk("no_overrun_on_refill", overrun, 0);

        // masked write, zero-wait memory
        req(2, 32'h0000_0200, 32'hAABB_CCDD, 1, 4'b0101, 0, 0, 1);
        tick();
        wait_idle(40);
        chk("grant_after_write", grant, 2);
        chk("no_timeout_yet", timeout_err, 0);

        // timeout, then a late mem_end that must be ignored
        req(3, 32'h0000_0500, 0, 0, 0, 12, 32'h5555_5555, 1);
        tick();
        wait_idle(40);
        chk("timeout_flag", timeout_err, 1);
        repeat (6) tick();
        chk("idle_after_late_end", busy, 0);

        // answer on the last allowed cycle completes normally
        req(3, 32'h0000_0504, 0, 0, 0, TO, 32'hCAFE_0001, 1);
        tick();
        wait_idle(40);

        // second begin on a pending port
        req(0, 32'h0000_0300, 0, 0, 0, 4, 32'h3333_0000, 1);
        tick();
        set_req(0, 32'h0000_0999, 0, 0, 0);
        tick();
        wait_idle(40);
        chk("overrun_flag", overrun, 4'b0001);

        // reset during WAIT: transaction abandoned with no completion
        req(1, 32'h0000_0400, 0, 0, 0, -1, 0, 0);
        tick();
        tick();
        tick();
        tick();
        chk("busy_in_wait", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset();
        repeat (12) tick();
        chk("no_late_req_end", end_q.size(), 0);
        chk("issues_drained", iss_q.size(), 0);
        chk("timeout_clear_after_rst", timeout_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
